combo_code_writer: RTL and testbench
====================================

# combo_code_writer

Programs the six-digit (three hex-pair) combination used by the lock checker. The user enters the digit pairs on switches `A`/`B` and strobes `enter` once per pair. When `COMBO_CONFIRM_EN` is defined, the user re-enters all three pairs as confirmation. The block then atomically commits the new code to `code_out` for the checker and reports the outcome on the same six active-low seven-segment displays.

## Interface
Parameters:
- `DEFAULT_CODE`, 24'h281996: code loaded at reset, pairs ordered [23:16]=pair0, [15:8]=pair1, [7:0]=pair2.

Ports:
- `clock`  input  1  single system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `A`  input  4  high digit of the current pair.
- `B`  input  4  low digit of the current pair.
- `enter`  input  1  asynchronous pushbutton level, active-high.
- `code_out`  output  24  committed combination.
- `code_load`  output  1  one-cycle strobe when `code_out` changes.
- `busy`  output  1  entry sequence in progress.
- `H1`..`H6`  output  7 each  seven-segment displays, active-low, bit0=segment a.

## Operation
- `enter` passes through a 2-flop synchronizer and a rising-edge detector, giving `enter_pulse`. A held button produces exactly one pulse.
- States: `IDLE`, `E0`, `E1`, `E2`, `C0`, `C1`, `C2`, `OK`, `FAIL`.
- `IDLE`/`OK`/`FAIL` + `enter_pulse`:
  - Capture `{A,B}` into `new0`.
  - Clear all other display positions.
  - Go to `E1`.
- `E1` + pulse: capture `new1`, go to `E2`.
- `E2` + pulse: capture `new2`.
  - With `COMBO_CONFIRM_EN`: go to `C0`.
  - Without it: commit and go to `OK`.
- `Ck` + pulse, k=0..2: compare `{A,B}` with `newk`.
  - On mismatch, go directly to `FAIL` with no commit.
  - On match at `C2`, commit and go to `OK`.
  - Otherwise advance to `C(k+1)`.
- `E0` is transient: it is the capture action of the first pulse and is not a resting state.
- Commit: `code_out <= {new0,new1,new2}`, and `code_load` pulses high for one cycle.
- `busy` is 1 in `E1`, `E2`, and `C0`–`C2`, and 0 otherwise.
- Display in entry states:
  - Pair k shows on H(2k+1) (A digit) and H(2k+2) (B digit), using the hex font 0–F.
  - Positions not yet entered are blank (7'h7F).
  - In `Ck`, the confirm digits overwrite positions 0..k-1; other positions show blank.
- `OK`: all six displays show "1" (7'h79).
- `FAIL`: all six displays show "-" (7'h3F).
- `code_out` never changes except on commit. The previous code remains valid throughout entry and on `FAIL`.

## Timing
- Reset values (async assert):
  - state=`IDLE`, `code_out`=`DEFAULT_CODE`, `code_load`=0, `busy`=0.
  - H1..H6 = 7'h7F (blank).
  - Synchronizer flops = 0.
- Pair capture happens on the 3rd rising edge after `enter` rises (2 synchronizer edges + 1 edge-detect edge). `A`/`B` must be stable from the first edge through the capture edge.
- Commit latency:
  - `code_out`, `code_load`, and the `OK` display all update on the same edge as the final capture.
  - `code_load` deasserts on the next edge.
- Minimum spacing between presses: `enter` low for ≥2 cycles. Shorter gaps may be merged into a single pulse.
- Reset asserted mid-entry: the sequence is abandoned and `code_out` returns to `DEFAULT_CODE`. Reset is not a way to preserve the previous user code; that behaviour is intentional.
- No timeout: the block waits indefinitely in any entry state.

## Configuration
- `COMBO_CONFIRM_EN`:
  - Defined: `E2` proceeds to confirmation states `C0`–`C2`, and a mismatch yields `FAIL`.
  - Undefined: `C0`–`C2` and `FAIL` are not compiled. `E2` commits directly, and displays never show dashes.

## Structure
- Package `combo_pkg` holds:
  - the state enum;
  - segment constants `SEG_BLANK`=7'h7F, `SEG_ONE`=7'h79, `SEG_DASH`=7'h3F (all active-low);
  - the hex-to-segment function;
  - the default code constant.
- One sub-module, `seg7_hex`, a combinational 4-bit to active-low 7-segment decoder. It is instantiated six times and is shared with the checker.

## Test plan
- Reset deasserted with no presses → `code_out`=24'h281996, `busy`=0, `code_load`=0, H1..H6=7'h7F.
- Enter pairs 12,34,56 then confirm 12,34,56 → on the final capture edge `code_out`=24'h123456 and `code_load` is high for 1 cycle; H1..H6=7'h79.
- Enter 12,34,56, then confirm 12,35 → `FAIL` after the 2nd confirm; H1..H6=7'h3F; `code_out` unchanged at 24'h281996; `code_load` never asserted.
- `enter` held high for 50 cycles with A=4'hA, B=4'hB → exactly one capture; H1=~7'h77, H2=~7'h7C, H3..H6=7'h7F; state `E1`.
- Reset pulsed after the first commit (code 24'h123456) during `E2` → `code_out`=24'h281996, state `IDLE`, blank displays.
- `COMBO_CONFIRM_EN` undefined: enter 9A,BC,DE → commit on the 3rd capture edge, `code_out`=24'h9ABCDE.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared types and constants for the combination code writer and lock checker.
// The confirmation states exist only when COMBO_CONFIRM_EN is defined.
package combo_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StE0,
    StE1,
    StE2,
`ifdef COMBO_CONFIRM_EN
    StC0,
    StC1,
    StC2,
    StFail,
`endif
    StOk
  } combo_state_e;

  localparam logic [6:0]  SEG_BLANK          = 7'h7F;
  localparam logic [6:0]  SEG_ONE            = 7'h79;
  localparam logic [6:0]  SEG_DASH           = 7'h3F;
  localparam logic [23:0] COMBO_DEFAULT_CODE = 24'h281996;

  // Active-low segments, bit0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] on;
    case (hex)
      4'h0:    on = 7'h3F;
      4'h1:    on = 7'h06;
      4'h2:    on = 7'h5B;
      4'h3:    on = 7'h4F;
      4'h4:    on = 7'h66;
      4'h5:    on = 7'h6D;
      4'h6:    on = 7'h7D;
      4'h7:    on = 7'h07;
      4'h8:    on = 7'h7F;
      4'h9:    on = 7'h6F;
      4'hA:    on = 7'h77;
      4'hB:    on = 7'h7C;
      4'hC:    on = 7'h39;
      4'hD:    on = 7'h5E;
      4'hE:    on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module seg7_hex
  import combo_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/combo_code_writer.sv
// Programs the three-pair lock combination from switch entry and shows progress on H1..H6.
// Define COMBO_CONFIRM_EN to require re-entry of all three pairs before commit.
module combo_code_writer
  import combo_pkg::*;
#(
  parameter logic [23:0] DEFAULT_CODE = COMBO_DEFAULT_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic        enter,
  output logic [23:0] code_out,
  output logic        code_load,
  output logic        busy,
  output logic [6:0]  H1,
  output logic [6:0]  H2,
  output logic [6:0]  H3,
  output logic [6:0]  H4,
  output logic [6:0]  H5,
  output logic [6:0]  H6
);

  combo_state_e state_q, state_d;
  logic         sync1_q, sync2_q, prev_q;
  logic         enter_pulse;
  logic [7:0]   new0_q, new0_d;
  logic [7:0]   new1_q, new1_d;
  logic [7:0]   new2_q, new2_d;
  logic [23:0]  code_q, code_d;
  logic         load_q, load_d;
  logic [7:0]   pair;

  logic [3:0]   digit [6];
  logic [6:0]   dec   [6];
  logic [6:0]   hseg  [6];
  int           shown;

  assign pair        = {A, B};
  assign enter_pulse = sync2_q & ~prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      new0_q  <= 8'h00;
      new1_q  <= 8'h00;
      new2_q  <= 8'h00;
      code_q  <= DEFAULT_CODE;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= enter;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      new0_q  <= new0_d;
      new1_q  <= new1_d;
      new2_q  <= new2_d;
      code_q  <= code_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    new0_d  = new0_q;
    new1_d  = new1_q;
    new2_d  = new2_q;
    code_d  = code_q;
    load_d  = 1'b0;
    if (enter_pulse) begin
      case (state_q)
        StIdle, StE0, StOk
`ifdef COMBO_CONFIRM_EN
        , StFail
`endif
        : begin
          new0_d  = pair;
          state_d = StE1;
        end
        StE1: begin
          new1_d  = pair;
          state_d = StE2;
        end
        StE2: begin
          new2_d = pair;
`ifdef COMBO_CONFIRM_EN
          state_d = StC0;
`else
          code_d  = {new0_q, new1_q, pair};
          load_d  = 1'b1;
          state_d = StOk;
`endif
        end
`ifdef COMBO_CONFIRM_EN
        StC0: state_d = (pair == new0_q) ? StC1 : StFail;
        StC1: state_d = (pair == new1_q) ? StC2 : StFail;
        StC2: begin
          if (pair == new2_q) begin
            code_d  = {new0_q, new1_q, new2_q};
            load_d  = 1'b1;
            state_d = StOk;
          end else begin
            state_d = StFail;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    shown = 0;
    case (state_q)
      StE1: begin
        busy  = 1'b1;
        shown = 1;
      end
      StE2: begin
        busy  = 1'b1;
        shown = 2;
      end
`ifdef COMBO_CONFIRM_EN
      // Confirmed digits equal the stored ones, so the stored pairs stand in for them.
      StC0: begin
        busy  = 1'b1;
        shown = 0;
      end
      StC1: begin
        busy  = 1'b1;
        shown = 1;
      end
      StC2: begin
        busy  = 1'b1;
        shown = 2;
      end
`endif
      default: begin
        busy  = 1'b0;
        shown = 0;
      end
    endcase
  end

  assign digit[0] = new0_q[7:4];
  assign digit[1] = new0_q[3:0];
  assign digit[2] = new1_q[7:4];
  assign digit[3] = new1_q[3:0];
  assign digit[4] = new2_q[7:4];
  assign digit[5] = new2_q[3:0];

  for (genvar g = 0; g < 6; g++) begin : g_seg
    seg7_hex u_seg (
      .hex_i (digit[g]),
      .seg_o (dec[g])
    );
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hseg[i] = SEG_BLANK;
      if (state_q == StOk) begin
        hseg[i] = SEG_ONE;
`ifdef COMBO_CONFIRM_EN
      end else if (state_q == StFail) begin
        hseg[i] = SEG_DASH;
`endif
      end else if ((i / 2) < shown) begin
        hseg[i] = dec[i];
      end
    end
  end

  assign H1        = hseg[0];
  assign H2        = hseg[1];
  assign H3        = hseg[2];
  assign H4        = hseg[3];
  assign H5        = hseg[4];
  assign H6        = hseg[5];
  assign code_out  = code_q;
  assign code_load = load_q;

endmodule

// File: tb/tb_combo_code_writer.sv
// Self-checking bench for combo_code_writer: entry-level model compared every cycle,
// plus literal expectations. Adapts its sequences to COMBO_CONFIRM_EN.
module tb_combo_code_writer;

`ifdef COMBO_CONFIRM_EN
  localparam bit CONFIRM = 1'b1;
`else
  localparam bit CONFIRM = 1'b0;
`endif

  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b0;
  logic [3:0]  A = 4'h0;
  logic [3:0]  B = 4'h0;
  logic [23:0] code_out;
  logic        code_load, busy;
  logic [6:0]  H1, H2, H3, H4, H5, H6;
  logic [6:0]  hv [6];

  combo_code_writer dut (
    .clock     (clock),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .enter     (enter),
    .code_out  (code_out),
    .code_load (code_load),
    .busy      (busy),
    .H1        (H1),
    .H2        (H2),
    .H3        (H3),
    .H4        (H4),
    .H5        (H5),
    .H6        (H6)
  );

  always #5 clock = ~clock;

  always_comb begin
    hv[0] = H1;
    hv[1] = H2;
    hv[2] = H3;
    hv[3] = H4;
    hv[4] = H5;
    hv[5] = H6;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model: rest kind 0 idle / 1 ok / 2 fail, -1 while an entry is in progress.
  logic [23:0] m_code;
  int          m_rest;
  bit          m_confirming;
  logic [7:0]  m_pairs [$];
  logic [7:0]  m_conf  [$];
  int          m_load_cyc;
  bit          cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_code       = 24'h281996;
    m_rest       = 0;
    m_confirming = 1'b0;
    m_pairs.delete();
    m_conf.delete();
    m_load_cyc   = -100;
  endfunction

  function automatic void model_commit();
    m_code     = {m_pairs[0], m_pairs[1], m_pairs[2]};
    m_load_cyc = cyc;
    m_rest     = 1;
  endfunction

  function automatic void model_press(input logic [7:0] ab);
    if (m_rest >= 0) begin
      m_pairs.delete();
      m_conf.delete();
      m_pairs.push_back(ab);
      m_rest       = -1;
      m_confirming = 1'b0;
    end else if (!m_confirming) begin
      m_pairs.push_back(ab);
      if (m_pairs.size() == 3) begin
        if (CONFIRM) m_confirming = 1'b1;
        else model_commit();
      end
    end else begin
      if (ab != m_pairs[m_conf.size()]) begin
        m_rest = 2;
      end else begin
        m_conf.push_back(ab);
        if (m_conf.size() == 3) model_commit();
      end
    end
  endfunction

  function automatic logic [6:0] exp_h(input int pos);
    int         p;
    logic [7:0] v;
    p = pos / 2;
    if (m_rest == 1) return 7'h79;
    if (m_rest == 2) return 7'h3F;
    if (m_rest == 0) return 7'h7F;
    if (m_confirming) begin
      if (p < m_conf.size()) v = m_conf[p];
      else return 7'h7F;
    end else begin
      if (p < m_pairs.size()) v = m_pairs[p];
      else return 7'h7F;
    end
    return ~FONT[(pos % 2 == 0) ? v[7:4] : v[3:0]];
  endfunction

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("code_out", {8'h0, code_out}, {8'h0, m_code});
      chk("code_load", {31'h0, code_load}, {31'h0, (cyc == m_load_cyc)});
      chk("busy", {31'h0, busy}, {31'h0, (m_rest < 0)});
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("H%0d", i + 1), {25'h0, hv[i]}, {25'h0, exp_h(i)});
      end
    end
  end

  // Holds enter for hold_cycles (>= 3), model updates just after the capture edge.
  task automatic press(input logic [7:0] ab, input int hold_cycles);
    @(negedge clock);
    A     = ab[7:4];
    B     = ab[3:0];
    enter = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    model_press(ab);
    repeat (hold_cycles - 3) @(posedge clock);
    @(negedge clock);
    enter = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // Same as press but returns right after the capture edge, leaving enter high.
  task automatic press_capture(input logic [7:0] ab);
    @(negedge clock);
    A     = ab[7:4];
    B     = ab[3:0];
    enter = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    model_press(ab);
  endtask

  task automatic release_enter();
    @(negedge clock);
    enter = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    enter = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    model_reset();
    cmp_on = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    chk("reset_code", {8'h0, code_out}, 32'h0028_1996);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_load", {31'h0, code_load}, 32'h0);
    chk("reset_H1", {25'h0, H1}, 32'h7F);
    chk("reset_H6", {25'h0, H6}, 32'h7F);

    // Full entry ending in a commit of 123456.
    press(8'h12, 4);
    press(8'h34, 4);
    if (CONFIRM) begin
      press(8'h56, 4);
      press(8'h12, 4);
      press(8'h34, 4);
    end
    press_capture(8'h56);
    chk("commit_code", {8'h0, code_out}, 32'h0012_3456);
    chk("commit_load", {31'h0, code_load}, 32'h1);
    chk("commit_H1", {25'h0, H1}, 32'h79);
    chk("commit_H4", {25'h0, H4}, 32'h79);
    @(posedge clock);
    #1;
    chk("commit_load_drop", {31'h0, code_load}, 32'h0);
    release_enter();

`ifdef COMBO_CONFIRM_EN
    do_reset();
    press(8'h12, 4);
    press(8'h34, 4);
    press(8'h56, 4);
    press(8'h12, 4);
    press(8'h35, 4);
    chk("fail_H1", {25'h0, H1}, 32'h3F);
    chk("fail_H6", {25'h0, H6}, 32'h3F);
    chk("fail_code", {8'h0, code_out}, 32'h0028_1996);
    chk("fail_busy", {31'h0, busy}, 32'h0);
`else
    press(8'h9A, 4);
    press(8'hBC, 4);
    press_capture(8'hDE);
    chk("direct_code", {8'h0, code_out}, 32'h009A_BCDE);
    chk("direct_load", {31'h0, code_load}, 32'h1);
    release_enter();
`endif

    // Button held for 50 cycles must capture exactly once.
    do_reset();
    press(8'hAB, 50);
    chk("held_H1", {25'h0, H1}, {25'h0, ~7'h77});
    chk("held_H2", {25'h0, H2}, {25'h0, ~7'h7C});
    chk("held_H3", {25'h0, H3}, 32'h7F);
    chk("held_H6", {25'h0, H6}, 32'h7F);
    chk("held_busy", {31'h0, busy}, 32'h1);

    // Reset during E2 after a user commit restores the default code.
    do_reset();
    press(8'h12, 4);
    press(8'h34, 4);
    press(8'h56, 4);
    if (CONFIRM) begin
      press(8'h12, 4);
      press(8'h34, 4);
      press(8'h56, 4);
    end
    chk("pre_reset_code", {8'h0, code_out}, 32'h0012_3456);
    press(8'h11, 4);
    press(8'h22, 4);
    chk("e2_H3", {25'h0, H3}, {25'h0, ~7'h5B});
    chk("e2_H5", {25'h0, H5}, 32'h7F);
    do_reset();
    chk("rst_mid_code", {8'h0, code_out}, 32'h0028_1996);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_H1", {25'h0, H1}, 32'h7F);

    repeat (4) @(posedge clock);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
